// File: rtl/uart_phy.sv
// Full-duplex 8-bit UART PHY, 1 start / 8 data LSB-first / 1 stop.
// Optional even parity is enabled by defining UART_PARITY_EN.
module uart_phy #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rdy,
  input  logic       rdy_clr,
  output logic       rx_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // ---------------- transmitter ----------------
  logic [2:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_data;
  logic          armed;   // blocks wr_en on the first edge after reset release

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_data  <= '0;
      armed    <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (tx_state == S_IDLE) begin
        if (wr_en && armed) begin
          tx_data  <= din;
          tx       <= 1'b0;
          tx_busy  <= 1'b1;
          tx_cnt   <= '0;
          tx_state <= S_START;
        end
      end else if (tx_cnt != BIT_LAST) begin
        tx_cnt <= tx_cnt + CNT_ONE;
      end else begin
        tx_cnt <= '0;
        case (tx_state)
          S_START: begin
            tx       <= tx_data[0];
            tx_bit   <= '0;
            tx_state <= S_DATA;
          end
          S_DATA: begin
            if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              tx       <= ^tx_data;
              tx_state <= S_PARITY;
`else
              tx       <= 1'b1;
              tx_state <= S_STOP;
`endif
            end else begin
              tx     <= tx_data[tx_bit + 3'd1];
              tx_bit <= tx_bit + 3'd1;
            end
          end
`ifdef UART_PARITY_EN
          S_PARITY: begin
            tx       <= 1'b1;
            tx_state <= S_STOP;
          end
`endif
          default: begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------- receiver ----------------
  logic [1:0]    rx_sync;
  logic          rx_s;
  logic [2:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_wait;  // after a framing error, wait for line high before re-arming
`ifdef UART_PARITY_EN
  logic          rx_perr;
`endif

  assign rx_s = rx_sync[1];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_sync <= 2'b11;
    end else begin
      rx_sync <= {rx_sync[0], rx};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_wait  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr  <= 1'b0;
`endif
      dout     <= '0;
      rdy      <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_err <= 1'b0;
      // a set later in this block overrides the clear
      if (rdy_clr) rdy <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (rx_wait) begin
            if (rx_s) rx_wait <= 1'b0;
          end else if (!rx_s) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt != HALF_LAST) begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end else begin
            rx_cnt <= '0;
            if (rx_s) begin
              rx_state <= S_IDLE;
            end else begin
              rx_bit   <= '0;
              rx_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rx_cnt != BIT_LAST) begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end else begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s, rx_sh[7:1]};
            if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state <= S_PARITY;
`else
              rx_state <= S_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (rx_cnt != BIT_LAST) begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end else begin
            rx_cnt   <= '0;
            rx_perr  <= rx_s ^ (^rx_sh);
            rx_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (rx_cnt != BIT_LAST) begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end else begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
            if (!rx_s) begin
              rx_err  <= 1'b1;
              rx_wait <= 1'b1;
            end
`ifdef UART_PARITY_EN
            else if (rx_perr) begin
              rx_err <= 1'b1;
            end
`endif
            else begin
              dout <= rx_sh;
              rdy  <= 1'b1;
              if (rdy) rx_err <= 1'b1;
            end
          end
        end
        default: begin
          rx_cnt   <= '0;
          rx_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
